// File: rtl/pipeline_handshake_sop.sv
// Registered sum-of-products pipeline: result = sum(a[i]*b[i]) + c.
// Every stage has its own valid/ready handshake; empty stages accept while later stages stall.
module pipeline_handshake_sop #(
    parameter int N_TERMS = 4,
    parameter int DW      = 8,
    parameter int SIGNED  = 0,
    parameter int RW      = 2*DW + $clog2(N_TERMS) + 1,
    parameter int S       = $clog2(N_TERMS) + 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_TERMS*DW-1:0]   a_flat,
    input  logic [N_TERMS*DW-1:0]   b_flat,
    input  logic [DW-1:0]           c,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    flush_i,
    output logic [RW-1:0]           result,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(S+1)-1:0]  occ_o
);

    localparam int L    = S - 2;           // adder-tree levels
    localparam int OW   = $clog2(S+1);
    localparam int HALF = N_TERMS / 2;

    logic [S-1:0]  v_q;
    logic [S:0]    rdy;
    logic [S-1:0]  up_v;
    logic [S-1:0]  load;

    // Level 0 holds N products; level k uses only the first N>>k entries.
    logic [RW-1:0] term_q [L+1][N_TERMS];
    logic [RW-1:0] c_q    [L+1];
    logic [RW-1:0] result_q;
    logic [RW-1:0] prod   [N_TERMS];

    function automatic logic [RW-1:0] ext(input logic [DW-1:0] x);
        logic fill;
        fill = (SIGNED != 0) && x[DW-1];
        return {{(RW-DW){fill}}, x};
    endfunction

    // A stage is ready when it is empty or everything downstream of it can move.
    always_comb begin
        logic chain;
        // NOTE: blocking assignments here build the ripple combinationally; '<=' would not.
        chain  = ready_i;
        rdy    = '0;
        rdy[S] = ready_i;
        for (int k = S-1; k >= 0; k--) begin
            chain  = chain | ~v_q[k];
            rdy[k] = chain;
        end
    end

    assign up_v    = {v_q[S-2:0], valid_i};
    assign load    = rdy[S-1:0] & up_v & {S{~flush_i}};
    assign ready_o = rdy[0] & ~flush_i;
    assign valid_o = v_q[S-1];
    assign result  = result_q;

    always_comb begin
        for (int i = 0; i < N_TERMS; i++) begin
            prod[i] = ext(a_flat[i*DW +: DW]) * ext(b_flat[i*DW +: DW]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q <= '0;
        end else if (flush_i) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (rdy[k]) v_q[k] <= up_v[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: data registers are reset too, so result reads 0 straight out of reset.
            for (int k = 0; k <= L; k++) begin
                for (int j = 0; j < N_TERMS; j++) term_q[k][j] <= '0;
                c_q[k] <= '0;
            end
            result_q <= '0;
        end else begin
            if (load[0]) begin
                for (int i = 0; i < N_TERMS; i++) term_q[0][i] <= prod[i];
                c_q[0] <= ext(c);
            end
            for (int k = 1; k <= L; k++) begin
                if (load[k]) begin
                    for (int j = 0; j < HALF; j++) begin
                        if (j < (N_TERMS >> k))
                            term_q[k][j] <= term_q[k-1][2*j] + term_q[k-1][2*j+1];
                    end
                    c_q[k] <= c_q[k-1];
                end
            end
            if (load[S-1]) result_q <= term_q[L][0] + c_q[L];
        end
    end

    always_comb begin
        occ_o = '0;
        for (int k = 0; k < S; k++) occ_o = occ_o + OW'(v_q[k]);
    end

endmodule

// File: tb/tb_pipeline_handshake_sop.sv
// Bench for pipeline_handshake_sop: directed scenarios plus random traffic,
// scored against an arithmetic reference and in-order expected-result queues.
module tb_pipeline_handshake_sop;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] a_flat, b_flat;
    logic [7:0]  c;
    logic        valid_i, ready_i, flush_i;
    logic        ready_o, valid_o, ready_o_s, valid_o_s;
    logic [18:0] result, result_s;
    logic [2:0]  occ_o, occ_s;

    int total = 0;
    int bad   = 0;

    logic [18:0] q_u[$];
    logic [18:0] q_s[$];
    bit          hold_prev = 0;
    logic [18:0] held_res;
    bit          last_in_fire;

    always #5 clk = ~clk;

    pipeline_handshake_sop #(.N_TERMS(4), .DW(8), .SIGNED(0)) u_dut (
        .clk(clk), .rstn(rstn), .a_flat(a_flat), .b_flat(b_flat), .c(c),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
        .result(result), .valid_o(valid_o), .ready_i(ready_i), .occ_o(occ_o)
    );

    pipeline_handshake_sop #(.N_TERMS(4), .DW(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rstn(rstn), .a_flat(a_flat), .b_flat(b_flat), .c(c),
        .valid_i(valid_i), .ready_o(ready_o_s), .flush_i(flush_i),
        .result(result_s), .valid_o(valid_o_s), .ready_i(ready_i), .occ_o(occ_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum of products, truncated to the 19-bit result.
    function automatic logic [18:0] sop(input logic [31:0] a, input logic [31:0] b,
                                        input logic [7:0] cc, input bit sgn);
        int   acc;
        int   x, y;
        logic [7:0] a8, b8;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            a8 = a[i*8 +: 8];
            b8 = b[i*8 +: 8];
            x  = sgn ? int'(signed'(a8)) : int'(a8);
            y  = sgn ? int'(signed'(b8)) : int'(b8);
            acc += x * y;
        end
        acc += sgn ? int'(signed'(cc)) : int'(cc);
        return acc[18:0];
    endfunction

    // One clock: sample handshakes mid-cycle, score, then advance past the edge.
    task automatic tick();
        bit in_fire, out_fire, flushing;
        #2;
        if (hold_prev) begin
            check("hold_valid", valid_o, 1);
            check("hold_result", result, held_res);
        end
        in_fire  = valid_i && ready_o;
        out_fire = valid_o && ready_i;
        flushing = flush_i;
        if (out_fire && !flushing) begin
            if (q_u.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                check("result_u", result, q_u.pop_front());
                check("result_s", result_s, q_s.pop_front());
            end
        end
        if (in_fire) begin
            q_u.push_back(sop(a_flat, b_flat, c, 1'b0));
            q_s.push_back(sop(a_flat, b_flat, c, 1'b1));
        end
        if (flushing) begin
            q_u.delete();
            q_s.delete();
        end
        last_in_fire = in_fire;
        hold_prev    = valid_o && !ready_i && !flushing;
        held_res     = result;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
        a_flat = {4{av}};
        b_flat = {4{bv}};
        c      = cv;
    endtask

    task automatic set_rand();
        a_flat = $urandom;
        b_flat = $urandom;
        c      = 8'($urandom);
    endtask

    task automatic run_one(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv,
                           input logic [18:0] eu, input logic [18:0] es);
        set_all(av, bv, cv);
        valid_i = 1;
        ready_i = 1;
        tick();
        check("lat_e0", valid_o, 0);
        valid_i = 0;
        tick();
        check("lat_e1", valid_o, 0);
        tick();
        check("lat_e2", valid_o, 0);
        tick();
        check("lat_valid", valid_o, 1);
        check("lat_result", result, eu);
        check("lat_result_s", result_s, es);
        tick();
        check("lat_occ_zero", occ_o, 0);
    endtask

    initial begin
        int sent;
        rstn = 0; valid_i = 0; ready_i = 0; flush_i = 0;
        a_flat = '0; b_flat = '0; c = '0;

        // Reset values, and a handshake during reset is ignored.
        #3;
        check("rst_result", result, 0);
        check("rst_valid", valid_o, 0);
        check("rst_occ", occ_o, 0);
        check("rst_ready", ready_o, 1);
        valid_i = 1;
        @(posedge clk); #1;
        check("rst_ignore_occ", occ_o, 0);
        valid_i = 0;
        rstn = 1;

        // Single item latency, unsigned max, signed negative.
        run_one(8'd2, 8'd2, 8'd2, 19'd18, 19'd18);
        run_one(8'hFF, 8'hFF, 8'hFF, 19'd260355, 19'd3);
        run_one(8'hFF, 8'd2, 8'd3, 19'd2043, 19'h7FFFB);

        // Back-to-back stream.
        ready_i = 1;
        valid_i = 1;
        for (int v = 2; v <= 4; v++) begin
            set_all(8'(v), 8'(v), 8'(v));
            check("stream_ready", ready_o, 1);
            tick();
        end
        valid_i = 0;
        tick();
        check("stream_r0", result, 18);
        tick();
        check("stream_r1", result, 39);
        tick();
        check("stream_r2", result, 68);
        tick();

        // Back-pressure: fill, then drain without gaps.
        ready_i = 0;
        valid_i = 1;
        for (int i = 0; i < 6; i++) begin
            set_rand();
            tick();
        end
        check("bp_ready", ready_o, 0);
        check("bp_occ", occ_o, 4);
        check("bp_valid", valid_o, 1);
        ready_i = 1;
        valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            check("drain_nogap", valid_o, 1);
            tick();
        end
        check("drain_empty", valid_o, 0);

        // Toggling ready_i while streaming values 1..8.
        sent = 0;
        valid_i = 1;
        for (int cyc = 0; cyc < 100 && sent < 8; cyc++) begin
            set_all(8'(sent + 1), 8'(sent + 1), 8'(sent + 1));
            ready_i = cyc[0];
            tick();
            if (last_in_fire) sent++;
        end
        check("toggle_sent", sent, 8);
        valid_i = 0;
        ready_i = 1;
        for (int i = 0; i < 10 && q_u.size() != 0; i++) tick();
        check("toggle_drained", q_u.size(), 0);
        tick();

        // Flush with three items in flight.
        ready_i = 0;
        valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            tick();
        end
        check("flush_pre_occ", occ_o, 3);
        flush_i = 1;
        #1;
        check("flush_ready", ready_o, 0);
        tick();
        flush_i = 0;
        valid_i = 0;
        check("flush_occ", occ_o, 0);
        check("flush_valid", valid_o, 0);
        ready_i = 1;
        for (int i = 0; i < 5; i++) tick();
        check("flush_quiet", valid_o, 0);

        // Asynchronous reset in mid-stream.
        valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            tick();
        end
        #2;
        rstn = 0;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_result", result, 0);
        check("midrst_occ", occ_o, 0);
        check("midrst_ready", ready_o, 1);
        check("midrst_valid_s", valid_o_s, 0);
        check("midrst_occ_s", occ_s, 0);
        check("midrst_ready_s", ready_o_s, 1);
        q_u.delete();
        q_s.delete();
        hold_prev = 0;
        valid_i = 0;
        @(negedge clk);
        rstn = 1;
        @(posedge clk); #1;
        check("postrst_occ", occ_o, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            set_rand();
            valid_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 9) < 7);
            flush_i = ($urandom_range(0, 29) == 0);
            tick();
        end
        flush_i = 0;
        valid_i = 0;
        ready_i = 1;
        for (int i = 0; i < 20 && q_u.size() != 0; i++) tick();
        check("final_drained", q_u.size(), 0);
        check("final_valid", valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
